// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT sizes, coefficient/frame types and bit-reversal helper
package ntt_pkg;
    localparam int NTT_N = 8;
    localparam int COEF_W = 8;
    localparam int IDX_W = $clog2(NTT_N);
    typedef logic [COEF_W-1:0] coef_t;
    typedef coef_t [NTT_N-1:0] frame_t;
    typedef enum logic {EMPTY, FULL} bank_st_t;
    function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] i);
        return {i[0], i[1], i[2]};
    endfunction
endpackage

// File: rtl/ntt_input_loader_if.sv
// ntt_input_loader_if: coefficient stream in, parallel frame out
interface ntt_input_loader_if;
    import ntt_pkg::*;
    logic flush;
    coef_t mod;
    coef_t in_data;
    logic in_valid;
    logic in_ready;
    frame_t frame_data;
    coef_t frame_mod;
    logic frame_valid;
    logic frame_ready;
    logic range_err;
    modport master (
        output flush, mod, in_data, in_valid, frame_ready,
        input in_ready, frame_data, frame_mod, frame_valid, range_err
    );
    modport slave (
        input flush, mod, in_data, in_valid, frame_ready,
        output in_ready, frame_data, frame_mod, frame_valid, range_err
    );
endinterface

// File: rtl/ntt_mod_reduce1.sv
// ntt_mod_reduce1: single conditional subtraction with out-of-range flag
module ntt_mod_reduce1
    import ntt_pkg::*;
(
    input  coef_t x,
    input  coef_t m,
    output coef_t y,
    output logic  ovf
);
    logic [COEF_W:0] x_w, m_w, diff;
    assign x_w = {1'b0, x};
    assign m_w = {1'b0, m};
    assign diff = x_w - m_w;
    assign y = x_w >= m_w ? diff[COEF_W-1:0] : x;
    assign ovf = x_w >= {m, 1'b0};
endmodule

// File: rtl/ntt_input_loader.sv
// ntt_input_loader: ping-pong loader writing reduced coefficients in bit-reversed order
module ntt_input_loader
    import ntt_pkg::*;
(
    input logic clk,
    input logic rst,
    ntt_input_loader_if.slave bus
);
    bank_st_t bank_q [2];
    bank_st_t bank_d [2];
    logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic err_q, err_d;
    frame_t data_q [2];
    coef_t mod_q [2];
    coef_t m, red;
    logic ovf, acc, drain, first, last;
    // the frame's modulus is taken live on its first word and latched for the rest
    assign first = cnt_q == '0;
    assign last = cnt_q == IDX_W'(NTT_N - 1);
    assign m = first ? bus.mod : mod_q[wr_ptr_q];
    assign bus.in_ready = bank_q[wr_ptr_q] == EMPTY;
    assign bus.frame_valid = bank_q[rd_ptr_q] == FULL;
    assign bus.frame_data = data_q[rd_ptr_q];
    assign bus.frame_mod = mod_q[rd_ptr_q];
    assign bus.range_err = err_q;
    assign acc = bus.in_valid & bus.in_ready & ~bus.flush;
    assign drain = bus.frame_valid & bus.frame_ready;
    ntt_mod_reduce1 u_red (.x(bus.in_data), .m(m), .y(red), .ovf(ovf));
    always_comb begin
        bank_d = bank_q;
        wr_ptr_d = wr_ptr_q ^ (acc & last);
        rd_ptr_d = rd_ptr_q ^ drain;
        cnt_d = (bus.flush || (acc && last)) ? '0 : cnt_q + IDX_W'(acc);
        err_d = err_q | (acc & (ovf | (first & (bus.mod < COEF_W'(2)))));
        if (acc && last) bank_d[wr_ptr_q] = FULL;
        if (drain) bank_d[rd_ptr_q] = EMPTY;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= '{EMPTY, EMPTY};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
            data_q <= '{default: '0};
            mod_q <= '{default: '0};
        end else begin
            bank_q <= bank_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (acc) begin
                data_q[wr_ptr_q][bitrev3(cnt_q)] <= red;
                if (first) mod_q[wr_ptr_q] <= bus.mod;
            end
        end
    end
endmodule
